key_debouncer: RTL and testbench
================================

Name: key_debouncer

Overview:
- Upstream input-conditioning stage for the board control unit.
- Takes the raw active-low push-button lines (KEY[3:0], pressed = 0), synchronises them to the system clock and debounces each one independently.
- Emits a clean debounced level per key, plus single-cycle press pulses (with optional auto-repeat) and release pulses.
- The control unit then increments its operand and operation registers on synchronous clk-domain pulses, not on raw button edges.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable clk samples needed to accept a level change (10 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000, clk cycles from the accepted press to the first auto-repeat pulse (0.5 s).
- REPEAT_PERIOD, 5000000, clk cycles between subsequent auto-repeat pulses (0.1 s).

Ports:
- clk, input, 1, system clock (CLOCK_50 at top level).
- rst_n, input, 1, asynchronous active-low reset.
- key_n, input, N_KEYS, raw button lines, active-low, asynchronous to clk.
- repeat_en, input, N_KEYS, per-key auto-repeat enable (synchronous, sampled every cycle).
- key_level, output, N_KEYS, debounced state, 1 = pressed.
- key_press, output, N_KEYS, 1-cycle pulse on accepted press and on each auto-repeat.
- key_release, output, N_KEYS, 1-cycle pulse on accepted release.
- any_press, output, 1, OR of key_press.

Behaviour:
- Reset (async assert, registered deassert handled by top):
  - synchroniser flops = 1 (released); key_level = 0; key_press = 0; key_release = 0; any_press = 0.
  - All counters = 0; every FSM in IDLE.
- Synchroniser: 2 flops per key; sync = inverted second-stage output (1 = pressed).
- Per-key FSM states:
  - IDLE (released, stable)
  - PRESS_CHK (counting toward pressed)
  - HELD (pressed, stable)
  - REL_CHK (counting toward released)
- IDLE: if sync = 1, go to PRESS_CHK with cnt = 1.
- PRESS_CHK:
  - sync = 0: return to IDLE, cnt = 0. No pulse.
  - sync = 1 and cnt = DEBOUNCE_CYCLES-1: go to HELD, key_level <= 1, key_press pulses next cycle, rpt_cnt cleared.
  - Otherwise cnt++.
- HELD:
  - sync = 0: go to REL_CHK with cnt = 1.
  - Otherwise, if repeat_en: rpt_cnt++. The first repeat pulse fires when rpt_cnt reaches REPEAT_DELAY-1. After that, pulses fire every REPEAT_PERIOD cycles; rpt_cnt reloads relative to REPEAT_PERIOD after each pulse.
  - If repeat_en = 0: rpt_cnt held at 0. Re-enabling while held restarts the full REPEAT_DELAY.
- REL_CHK: mirror of PRESS_CHK.
  - sync = 1: return to HELD. rpt_cnt is not cleared, so the repeat phase is preserved.
  - Debounce complete: go to IDLE, key_level <= 0, key_release pulses.
- Latency: a clean raw edge at cycle 0 makes key_level and the pulse visible at cycle DEBOUNCE_CYCLES+2 (2 sync + DEBOUNCE_CYCLES counting; the pulse is registered).
- Pulses are exactly 1 cycle wide. key_press and key_release are never both high for the same key in the same cycle.
- Glitches shorter than DEBOUNCE_CYCLES produce no output change and no pulse.
- Counter widths are $clog2(max+1). Counters saturate and never wrap; cnt cannot exceed DEBOUNCE_CYCLES-1.
- Keys are fully independent. Simultaneous presses on several keys give simultaneous pulses; any_press = OR of key_press.
- Reset mid-debounce or while held: all state is discarded immediately. If the key is still held after reset release, a full debounce runs again and a fresh key_press is produced. No key_release is emitted for the interrupted press.

Decomposition:
- Shared package key_pkg holds:
  - the FSM state enum (IDLE, PRESS_CHK, HELD, REL_CHK)
  - the default timing constants
  - a helper function for counter width
- One sub-module, key_debounce_ch: synchroniser, FSM and counters for a single key, with 1-bit ports.
- key_debouncer instantiates N_KEYS copies via generate and forms any_press.

Test Plan (parameters DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- Clean press: key_n[0] 1->0 at cycle 0, held -> key_level[0]=1 and key_press[0]=1 at cycle 10 only; other bits stay 0.
- Bounce: key_n[1] toggles low for 3 cycles, high for 2, then low for good -> exactly one key_press[1] pulse, 10 cycles after the final low edge; no pulse for the 3-cycle glitch.
- Release: after a held key_n[2] returns to 1 -> key_release[2] pulse 10 cycles later, key_level[2]=0, and no key_press in the same cycle.
- Auto-repeat: repeat_en[3]=1, key_n[3] held 60 cycles -> key_press[3] pulses at +10, +30, +35, +40, +45, ... relative to the edge; with repeat_en[3]=0 only the +10 pulse.
- Simultaneous: key_n = 4'b0000 at the same cycle -> key_press = 4'b1111 and any_press=1 in one cycle.
- Reset mid-operation: assert rst_n=0 at cycle 5 of a debounce, release at cycle 7 with the key still low -> all outputs 0 during reset; key_press arrives 10 cycles after reset release; no key_release.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the key debouncer: channel FSM states, timing
// constants and the counter-width helper.
package key_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPressChk,
    StHeld,
    StRelChk
  } key_state_e;

  localparam int unsigned DefNKeys          = 4;
  localparam int unsigned DefDebounceCycles = 500000;
  localparam int unsigned DefRepeatDelay    = 25000000;
  localparam int unsigned DefRepeatPeriod   = 5000000;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key conditioning bus: raw active-low keys and repeat enables in, clean levels
// and clk-domain pulses out.
interface key_debouncer_if
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS = DefNKeys
);
  logic [N_KEYS-1:0] i_key_n;
  logic [N_KEYS-1:0] i_repeat_en;
  logic [N_KEYS-1:0] o_key_level;
  logic [N_KEYS-1:0] o_key_press;
  logic [N_KEYS-1:0] o_key_release;
  logic              o_any_press;

  modport master (
    output i_key_n, i_repeat_en,
    input  o_key_level, o_key_press, o_key_release, o_any_press
  );

  modport slave (
    input  i_key_n, i_repeat_en,
    output o_key_level, o_key_press, o_key_release, o_any_press
  );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, auto-repeat timer and
// registered press/release pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned CntW   = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int unsigned RptMax =
      ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int unsigned RptW   = cnt_width(RptMax);

  localparam logic [CntW-1:0] CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] RptFirst = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptNext  = RptW'(REPEAT_PERIOD - 1);

  logic            r_sync1, r_sync2;
  logic            w_sync;
  key_state_e      r_state, w_state;
  logic [CntW-1:0] r_cnt, w_cnt;
  logic [RptW-1:0] r_rpt, w_rpt;
  logic [RptW-1:0] w_rpt_target;
  logic            r_rpt_phase, w_rpt_phase;
  logic            r_level, w_level;
  logic            r_press, w_press;
  logic            r_release, w_release;

  assign w_sync       = ~r_sync2;
  assign w_rpt_target = r_rpt_phase ? RptNext : RptFirst;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_rpt       = r_rpt;
    w_rpt_phase = r_rpt_phase;
    w_level     = r_level;
    w_press     = 1'b0;
    w_release   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_sync) begin
          w_state = StPressChk;
          w_cnt   = CntW'(1);
        end
      end
      StPressChk: begin
        if (!w_sync) begin
          w_state = StIdle;
          w_cnt   = '0;
        end else if (r_cnt == CntLast) begin
          w_state     = StHeld;
          w_cnt       = '0;
          w_level     = 1'b1;
          w_press     = 1'b1;
          w_rpt       = '0;
          w_rpt_phase = 1'b0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      StHeld: begin
        if (!w_sync) begin
          w_state = StRelChk;
          w_cnt   = CntW'(1);
        end
      end
      StRelChk: begin
        if (w_sync) begin
          w_state = StHeld;
          w_cnt   = '0;
        end else if (r_cnt == CntLast) begin
          w_state   = StIdle;
          w_cnt     = '0;
          w_level   = 1'b0;
          w_release = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state = StIdle;
        w_cnt   = '0;
      end
    endcase

    // Repeat timer runs only while the key is accepted as pressed and the raw line agrees,
    // so a bounce during release freezes the phase instead of restarting it.
    if (r_level && w_sync) begin
      if (i_repeat_en) begin
        if (r_rpt >= w_rpt_target) begin
          w_press     = 1'b1;
          w_rpt       = '0;
          w_rpt_phase = 1'b1;
        end else begin
          w_rpt = r_rpt + 1'b1;
        end
      end else begin
        w_rpt       = '0;
        w_rpt_phase = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rpt       <= '0;
      r_rpt_phase <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
    end else begin
      r_sync1     <= i_key_n;
      r_sync2     <= r_sync1;
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_rpt       <= w_rpt;
      r_rpt_phase <= w_rpt_phase;
      r_level     <= w_level;
      r_press     <= w_press;
      r_release   <= w_release;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS independent active-low buttons into clean levels and
// single-cycle press/release pulses for the control unit.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS          = DefNKeys,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input  logic            clk,
  input  logic            rst_n,
  key_debouncer_if.slave  kif
);

  logic [N_KEYS-1:0] w_level;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_release;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_key_n     (kif.i_key_n[g]),
      .i_repeat_en (kif.i_repeat_en[g]),
      .o_level     (w_level[g]),
      .o_press     (w_press[g]),
      .o_release   (w_release[g])
    );
  end

  assign kif.o_key_level   = w_level;
  assign kif.o_key_press   = w_press;
  assign kif.o_key_release = w_release;
  assign kif.o_any_press   = |w_press;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed timing scenarios plus randomized key activity,
// every cycle compared against a run-length behavioural model.
module tb_key_debouncer;

  localparam int NK = 4;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  key_debouncer_if #(.N_KEYS(NK)) kif ();

  key_debouncer #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t0       = 0;
  int watch    = 0;
  int pq[$];
  int rq[$];
  int exp_rpt[8] = '{10, 30, 35, 40, 45, 50, 55, 60};

  // Reference model: raw line delayed two cycles, then a run-length of disagreeing samples.
  bit [NK-1:0] m_s1, m_s2, m_level, m_first, m_press, m_rel;
  int          m_run[NK];
  int          m_elapsed[NK];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1    = '1;
    m_s2    = '1;
    m_level = '0;
    m_first = '1;
    m_press = '0;
    m_rel   = '0;
    for (int k = 0; k < NK; k++) begin
      m_run[k]     = 0;
      m_elapsed[k] = 0;
    end
  endtask

  task automatic model_step();
    bit s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_press = '0;
    m_rel   = '0;
    for (int k = 0; k < NK; k++) begin
      s = ~m_s2[k];
      if (s != m_level[k]) begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          m_level[k] = s;
          m_run[k]   = 0;
          if (s) begin
            m_press[k]   = 1'b1;
            m_elapsed[k] = 0;
            m_first[k]   = 1'b1;
          end else begin
            m_rel[k] = 1'b1;
          end
        end
      end else begin
        m_run[k] = 0;
        if (m_level[k]) begin
          if (kif.i_repeat_en[k]) begin
            m_elapsed[k]++;
            if (m_elapsed[k] == (m_first[k] ? RD : RP)) begin
              m_press[k]   = 1'b1;
              m_elapsed[k] = 0;
              m_first[k]   = 1'b0;
            end
          end else begin
            m_elapsed[k] = 0;
            m_first[k]   = 1'b1;
          end
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = kif.i_key_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_eq("key_level", 32'(kif.o_key_level), 32'(m_level));
    check_eq("key_press", 32'(kif.o_key_press), 32'(m_press));
    check_eq("key_release", 32'(kif.o_key_release), 32'(m_rel));
    check_eq("any_press", 32'(kif.o_any_press), 32'(|m_press));
    check_eq("press_and_release", 32'(kif.o_key_press & kif.o_key_release), 32'd0);
    if (kif.o_key_press[watch]) pq.push_back(cyc - t0);
    if (kif.o_key_release[watch]) rq.push_back(cyc - t0);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start(input int key);
    watch = key;
    t0    = cyc;
    pq.delete();
    rq.delete();
  endtask

  task automatic release_all();
    kif.i_key_n = '1;
    run(14);
  endtask

  initial begin
    kif.i_key_n     = '1;
    kif.i_repeat_en = '0;
    model_reset();
    run(2);
    check_eq("reset_level", 32'(kif.o_key_level), 32'd0);
    check_eq("reset_press", 32'(kif.o_key_press), 32'd0);
    rst_n = 1'b1;
    run(3);

    // Clean press on key 0
    start(0);
    kif.i_key_n[0] = 1'b0;
    run(15);
    check_eq("clean_press_count", 32'(pq.size()), 32'd1);
    check_eq("clean_press_cycle", 32'((pq.size() > 0) ? pq[0] : -1), 32'd10);
    check_eq("clean_level", 32'(kif.o_key_level), 32'b0001);
    release_all();

    // Bounce on key 1: 3 low, 2 high, then low for good at relative cycle 5
    start(1);
    kif.i_key_n[1] = 1'b0;
    run(3);
    kif.i_key_n[1] = 1'b1;
    run(2);
    kif.i_key_n[1] = 1'b0;
    run(20);
    check_eq("bounce_press_count", 32'(pq.size()), 32'd1);
    check_eq("bounce_press_cycle", 32'((pq.size() > 0) ? pq[0] : -1), 32'd15);
    release_all();

    // Release on key 2
    kif.i_key_n[2] = 1'b0;
    run(15);
    start(2);
    kif.i_key_n[2] = 1'b1;
    run(15);
    check_eq("release_count", 32'(rq.size()), 32'd1);
    check_eq("release_cycle", 32'((rq.size() > 0) ? rq[0] : -1), 32'd10);
    check_eq("release_no_press", 32'(pq.size()), 32'd0);
    check_eq("release_level", 32'(kif.o_key_level[2]), 32'd0);

    // Auto-repeat on key 3
    kif.i_repeat_en[3] = 1'b1;
    start(3);
    kif.i_key_n[3] = 1'b0;
    run(60);
    check_eq("repeat_count", 32'(pq.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check_eq("repeat_cycle", 32'((i < pq.size()) ? pq[i] : -1), 32'(exp_rpt[i]));
    release_all();
    kif.i_repeat_en[3] = 1'b0;
    start(3);
    kif.i_key_n[3] = 1'b0;
    run(60);
    check_eq("norepeat_count", 32'(pq.size()), 32'd1);
    check_eq("norepeat_cycle", 32'((pq.size() > 0) ? pq[0] : -1), 32'd10);
    release_all();

    // Simultaneous press of all keys
    kif.i_key_n = '0;
    run(9);
    tick();
    check_eq("simul_press", 32'(kif.o_key_press), 32'hf);
    check_eq("simul_any", 32'(kif.o_any_press), 32'd1);
    release_all();

    // Reset in the middle of a debounce
    kif.i_key_n[0] = 1'b0;
    run(5);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_level", 32'(kif.o_key_level), 32'd0);
    run(2);
    check_eq("rst_press", 32'(kif.o_key_press), 32'd0);
    rst_n = 1'b1;
    start(0);
    run(15);
    check_eq("rst_press_count", 32'(pq.size()), 32'd1);
    check_eq("rst_press_cycle", 32'((pq.size() > 0) ? pq[0] : -1), 32'd10);
    check_eq("rst_no_release", 32'(rq.size()), 32'd0);
    release_all();

    // Randomized activity with varying bounce density
    for (int blk = 0; blk < 9; blk++) begin
      int den;
      den = (blk % 3 == 0) ? 4 : ((blk % 3 == 1) ? 12 : 60);
      for (int i = 0; i < 500; i++) begin
        for (int k = 0; k < NK; k++)
          if ($urandom_range(0, den - 1) == 0) kif.i_key_n[k] = ~kif.i_key_n[k];
        if ($urandom_range(0, 49) == 0) kif.i_repeat_en = NK'($urandom());
        rst_n = ($urandom_range(0, 1499) != 0);
        tick();
      end
    end
    rst_n = 1'b1;
    release_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
